key_debounce: RTL and testbench

Debounces and conditions one raw mechanical key input before it reaches the LED control logic. The block synchronises the asynchronous pin to the system clock and filters contact bounce with a four-state machine. It outputs a clean key level in the same polarity as the raw input, so it drives the `led` block's `key` input directly. It also produces single-cycle press/release event pulses and an optional long-press pulse.

---
 rtl/key_debounce.sv | 138 +++++++++++++
 tb/tb_key_debounce.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Key synchroniser + four-state debounce filter with press/release pulses.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to compile in the long-press pulse.
module key_debounce #(
    parameter logic ACTIVE_LEVEL = 1'b0,
    parameter int   DB_CNT_MAX   = 999_999,
    parameter int   LONG_CNT_MAX = 49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W = (DB_CNT_MAX > 0) ? $clog2(DB_CNT_MAX + 1) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CNT_MAX);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_PRESS_FILT = 2'd1;
    localparam logic [1:0] S_PRESSED    = 2'd2;
    localparam logic [1:0] S_REL_FILT   = 2'd3;

    logic            r_key_s1, r_key_s;
    logic [1:0]      r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_key_level, r_press_pulse, r_release_pulse;
    logic            w_act;
    logic            w_enter_pressed;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_s1 <= ~ACTIVE_LEVEL;
            r_key_s  <= ~ACTIVE_LEVEL;
        end else begin
            r_key_s1 <= key_in;
            r_key_s  <= r_key_s1;
        end
    end

    assign w_act           = (r_key_s == ACTIVE_LEVEL);
    assign w_enter_pressed = (r_state == S_PRESS_FILT) && w_act && (r_db_cnt == DB_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state         <= S_IDLE;
            r_db_cnt        <= '0;
            r_key_level     <= ~ACTIVE_LEVEL;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_act) begin
                        r_state  <= S_PRESS_FILT;
                        r_db_cnt <= '0;
                    end
                end
                S_PRESS_FILT: begin
                    if (!w_act) begin
                        r_state  <= S_IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state       <= S_PRESSED;
                        r_key_level   <= ACTIVE_LEVEL;
                        r_press_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!w_act) begin
                        r_state  <= S_REL_FILT;
                        r_db_cnt <= '0;
                    end
                end
                default: begin
                    // Release filter: any active sample falls back to PRESSED
                    if (w_act) begin
                        r_state  <= S_PRESSED;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state         <= S_IDLE;
                        r_key_level     <= ~ACTIVE_LEVEL;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign key_level     = r_key_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int LG_W = (LONG_CNT_MAX > 0) ? $clog2(LONG_CNT_MAX + 1) : 1;
    localparam logic [LG_W-1:0] LG_MAX = LG_W'(LONG_CNT_MAX);

    logic [LG_W-1:0] r_long_cnt;
    logic            r_long_done;
    logic            r_long_pulse;

    // r_long_done keeps the saturated count from re-firing while still held
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_long_cnt   <= '0;
            r_long_done  <= 1'b0;
            r_long_pulse <= 1'b0;
        end else begin
            r_long_pulse <= 1'b0;
            if (w_enter_pressed || r_state == S_IDLE) begin
                r_long_cnt  <= '0;
                r_long_done <= 1'b0;
            end else if (r_state == S_PRESSED || r_state == S_REL_FILT) begin
                if (r_long_cnt == LG_MAX) begin
                    if (!r_long_done) begin
                        r_long_pulse <= 1'b1;
                        r_long_done  <= 1'b1;
                    end
                end else begin
                    r_long_cnt <= r_long_cnt + 1'b1;
                end
            end
        end
    end

    assign long_pulse = r_long_pulse;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulses (kind, cycle) are queued
// as stimulus is driven and matched by a negedge monitor.
module tb_key_debounce;

    localparam int DB  = 3;
    localparam int LNG = 15;
    localparam int LAT = DB + 3;
    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_in = 1'b1;
    logic key_level, press_pulse, release_pulse, long_pulse;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  long_seen = 0;
    logic [2:0] mon_p;
    ev_t mon_e;

    key_debounce #(
        .ACTIVE_LEVEL(1'b0),
        .DB_CNT_MAX  (DB),
        .LONG_CNT_MAX(LNG)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_in       (key_in),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pops one expected event per observed pulse and checks kind and cycle
    always @(negedge sys_clk) begin
        mon_p = {long_pulse, release_pulse, press_pulse};
        if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
            failures++;
            $display("FAIL both_pulses cyc=%0d press=1 release=1 required not both", cyc);
        end
        for (int k = 0; k < 3; k++) begin
            if (mon_p[k] === 1'b1) begin
                checks++;
                if (k == K_LONG) long_seen++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected kind=%0d cyc=%0d required no pulse", k, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.kind !== k || mon_e.cyc !== cyc) begin
                        failures++;
                        $display("FAIL sb_event got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                                 k, cyc, mon_e.kind, mon_e.cyc);
                    end
                end
                if (k != K_LONG) begin
                    checks++;
                    if (key_level !== (k == K_REL)) begin
                        failures++;
                        $display("FAIL level_at_pulse kind=%0d key_level=%b required %b",
                                 k, key_level, (k == K_REL));
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Key must be in pressed state on entry; schedules the long pulse if built in
    task automatic push_long(input int press_cyc);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        push_ev(K_LONG, press_cyc + LNG + 1);
`else
        if (press_cyc < 0) push_ev(K_LONG, 0);
`endif
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({key_level, press_pulse, release_pulse, long_pulse} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_values lvl/pr/rel/long=%b required 1000",
                         {key_level, press_pulse, release_pulse, long_pulse});
            end
        end
        sys_rst_n = 1'b1;
        wait_cyc(3);
    endtask

    task automatic test_clean_press();
        int c;
        c = cyc;
        key_in = 1'b0;
        push_ev(K_PRESS, c + LAT + 1);
        push_long(c + LAT + 1);
        wait_cyc(LAT);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL press_early key_level=%b required 1 at cyc=%0d", key_level, cyc);
        end
        wait_cyc(2);
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL press_level key_level=%b required 0", key_level);
        end
    endtask

    task automatic test_long_press();
        int ls0;
        ls0 = long_seen;
        wait_cyc(LNG + 1 + 50);
        checks++;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        if (long_seen - ls0 !== 1) begin
            failures++;
            $display("FAIL long_count got=%0d required 1", long_seen - ls0);
        end
`else
        if (long_seen - ls0 !== 0) begin
            failures++;
            $display("FAIL long_count got=%0d required 0", long_seen - ls0);
        end
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL long_pending got=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_clean_release();
        int c;
        c = cyc;
        key_in = 1'b1;
        push_ev(K_REL, c + LAT + 1);
        wait_cyc(LAT);
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL release_early key_level=%b required 0", key_level);
        end
        wait_cyc(4);
        checks++;
        if (key_level !== 1'b1 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL release_level key_level=%b pending=%0d required 1/0",
                     key_level, exp_q.size());
        end
    endtask

    task automatic test_press_bounce();
        int c;
        key_in = 1'b0;
        wait_cyc(2);
        key_in = 1'b1;
        wait_cyc(1);
        c = cyc;
        key_in = 1'b0;
        push_ev(K_PRESS, c + LAT + 1);
        push_long(c + LAT + 1);
        wait_cyc(LAT);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL bounce_early key_level=%b required 1", key_level);
        end
        wait_cyc(LNG + 6);
        checks++;
        if (key_level !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL bounce_press key_level=%b pending=%0d required 0/0",
                     key_level, exp_q.size());
        end
        test_clean_release();
    endtask

    task automatic test_reset_mid_filter();
        int c;
        key_in = 1'b0;
        wait_cyc(5);
        sys_rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            checks++;
            if (key_level !== 1'b1 || press_pulse !== 1'b0) begin
                failures++;
                $display("FAIL midrst_hold key_level=%b press=%b required 1/0",
                         key_level, press_pulse);
            end
        end
        c = cyc;
        sys_rst_n = 1'b1;
        push_ev(K_PRESS, c + LAT + 1);
        push_long(c + LAT + 1);
        wait_cyc(LAT);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL midrst_early key_level=%b required 1", key_level);
        end
        wait_cyc(LNG + 8);
        checks++;
        if (key_level !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL midrst_press key_level=%b pending=%0d required 0/0",
                     key_level, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_long_press();
        test_clean_release();
        test_press_bounce();
        test_reset_mid_filter();
        wait_cyc(3);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL final_pending got=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
